// File: rtl/axi_slave_mem.sv
// AXI3 slave backed by a DEPTH x 32-bit memory; one burst outstanding per direction.
// Define AXI_SLAVE_WRAP_EN to support WRAP bursts; otherwise WRAP is reserved (SLVERR).
module axi_slave_mem #(
  parameter int DEPTH    = 64,
  parameter int BUSWIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [3:0]            AWID,
  input  logic [31:0]           AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            WID,
  input  logic [BUSWIDTH-1:0]   WDATA,
  input  logic [BUSWIDTH/8-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [3:0]            BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [3:0]            ARID,
  input  logic [31:0]           ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [3:0]            RID,
  output logic [BUSWIDTH-1:0]   RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;
`ifdef AXI_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic [BUSWIDTH-1:0] mem [DEPTH];

  // WRAP window is (len+1)*4 bytes; only valid lens reach here without an error.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [3:0] len);
    logic [31:0] mask;
    mask      = {26'd0, len, 2'b11};
    next_addr = a;
    if (burst == 2'b01)
      next_addr = a + 32'd4;
    else if (burst == 2'b10 && WRAP_EN)
      next_addr = (a & ~mask) | ((a + 32'd4) & mask);
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
    burst_err = (size != 3'b010) || (burst == 2'b11) ||
                (burst == 2'b10 && (!WRAP_EN ||
                 !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)));
  endfunction

  // ---------------- write path ----------------
  wstate_e     w_state_q;
  logic [3:0]  w_id_q, w_len_q, w_cnt_q, bid_q;
  logic [31:0] w_addr_q;
  logic [1:0]  w_burst_q, bresp_q;
  logic        w_err_q, w_resp_err_q;
  logic        w_fire, w_beat_err, w_final, w_resp_err_d;

  assign AWREADY      = (w_state_q == W_IDLE) && !ARESET;
  assign WREADY       = (w_state_q == W_DATA);
  assign BVALID       = (w_state_q == W_RESP);
  assign BID          = bid_q;
  assign BRESP        = bresp_q;
  assign w_fire       = WREADY && WVALID;
  assign w_beat_err   = w_err_q || (w_addr_q >= MEM_BYTES);
  assign w_final      = (w_cnt_q == w_len_q);
  assign w_resp_err_d = w_resp_err_q || w_beat_err || (WLAST != w_final);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q    <= W_IDLE;
      w_id_q       <= '0;
      w_len_q      <= '0;
      w_cnt_q      <= '0;
      w_addr_q     <= '0;
      w_burst_q    <= '0;
      w_err_q      <= 1'b0;
      w_resp_err_q <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: if (AWVALID) begin
          w_id_q       <= AWID;
          w_addr_q     <= AWADDR;
          w_len_q      <= AWLEN;
          w_burst_q    <= AWBURST;
          w_err_q      <= burst_err(AWSIZE, AWBURST, AWLEN);
          w_cnt_q      <= '0;
          w_resp_err_q <= 1'b0;
          w_state_q    <= W_DATA;
        end
        W_DATA: if (WVALID) begin
          w_addr_q     <= next_addr(w_addr_q, w_burst_q, w_len_q);
          w_cnt_q      <= w_cnt_q + 4'd1;
          w_resp_err_q <= w_resp_err_d;
          if (w_final) begin
            bid_q     <= w_id_q;
            bresp_q   <= w_resp_err_d ? SLVERR : OKAY;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (BREADY) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge ACLK) begin
    if (w_fire && !w_beat_err)
      for (int b = 0; b < BUSWIDTH / 8; b++)
        if (WSTRB[b]) mem[w_addr_q[AW+1:2]][8*b +: 8] <= WDATA[8*b +: 8];
  end

  // ---------------- read path ----------------
  rstate_e             r_state_q;
  logic [3:0]          rid_q, r_len_q, r_cnt_q;
  logic [31:0]         r_addr_q, r_ld_addr;
  logic [1:0]          r_burst_q, rresp_q, r_ld_burst;
  logic [3:0]          r_ld_len;
  logic                r_err_q, rlast_q, r_ld_err, r_idle;
  logic [BUSWIDTH-1:0] rdata_q, r_ld_data;

  assign ARREADY = (r_state_q == R_IDLE) && !ARESET;
  assign RVALID  = (r_state_q == R_DATA);
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

  // Beat to load next: the AR address when idle, else the advanced burst address.
  assign r_idle     = (r_state_q == R_IDLE);
  assign r_ld_addr  = r_idle ? ARADDR  : r_addr_q;
  assign r_ld_burst = r_idle ? ARBURST : r_burst_q;
  assign r_ld_len   = r_idle ? ARLEN   : r_len_q;
  assign r_ld_err   = (r_idle ? burst_err(ARSIZE, ARBURST, ARLEN) : r_err_q) ||
                      (r_ld_addr >= MEM_BYTES);
  assign r_ld_data  = r_ld_err ? '0 : mem[r_ld_addr[AW+1:2]];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ARVALID) begin
          rid_q     <= ARID;
          r_len_q   <= ARLEN;
          r_burst_q <= ARBURST;
          r_err_q   <= burst_err(ARSIZE, ARBURST, ARLEN);
          r_cnt_q   <= '0;
          rdata_q   <= r_ld_data;
          rresp_q   <= r_ld_err ? SLVERR : OKAY;
          rlast_q   <= (ARLEN == 4'd0);
          r_addr_q  <= next_addr(r_ld_addr, r_ld_burst, r_ld_len);
          r_state_q <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          if (rlast_q) begin
            rlast_q   <= 1'b0;
            r_state_q <= R_IDLE;
          end else begin
            r_cnt_q  <= r_cnt_q + 4'd1;
            rdata_q  <= r_ld_data;
            rresp_q  <= r_ld_err ? SLVERR : OKAY;
            rlast_q  <= (r_cnt_q + 4'd1 == r_len_q);
            r_addr_q <= next_addr(r_ld_addr, r_ld_burst, r_ld_len);
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT, WID};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, strobes, WLAST errors, range, WRAP, reset.
module tb_axi_slave_mem;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic [3:0]  AWID = '0, AWLEN = '0, AWCACHE = '0, WID = '0, ARID = '0, ARLEN = '0, ARCACHE = '0;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0;
  logic [2:0]  AWSIZE = 3'b010, AWPROT = '0, ARSIZE = 3'b010, ARPROT = '0;
  logic [1:0]  AWBURST = '0, AWLOCK = '0, ARBURST = '0, ARLOCK = '0;
  logic [3:0]  WSTRB = '0;
  logic        AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [3:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;

  axi_slave_mem #(.DEPTH(64), .BUSWIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int nvec = 0, nerr = 0;
  logic [2:0]  sz = 3'b010;
  logic [31:0] rdv [16];
  logic [1:0]  rrv [16];
  logic        rlv [16];
  logic [3:0]  rid_g;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                    input int lastb, output logic [3:0] ob, output logic [1:0] orsp);
    int n;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = sz; AWBURST = burst; AWVALID = 1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) chk("aw_wait", AWREADY, 1);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge ACLK);
      AWVALID = 0;
      WDATA = base + i; WSTRB = strb; WLAST = (i == lastb); WVALID = 1;
      n = 0;
      while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) chk("w_wait", WREADY, 1);
    end
    @(negedge ACLK);
    WVALID = 0; WLAST = 0; BREADY = 1;
    n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("b_latency", n, 0);
    ob = BID; orsp = BRESP;
    @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] burst, input int stall_beat, input int stall_n);
    int n;
    logic [31:0] d0;
    logic l0;
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = sz; ARBURST = burst; ARVALID = 1; RREADY = 0;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) chk("ar_wait", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 0;
    chk("r_latency", RVALID, 1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) chk("r_wait", RVALID, 1);
      if (i == stall_beat) begin
        d0 = RDATA; l0 = RLAST;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge ACLK);
          chk("r_hold_data", RDATA, d0);
          chk("r_hold_last", RLAST, l0);
        end
      end
      rdv[i] = RDATA; rrv[i] = RRESP; rlv[i] = RLAST; rid_g = RID;
      RREADY = 1;
      @(negedge ACLK);
      RREADY = 0;
    end
  endtask

  task automatic beat(input string t, input int i, input logic [31:0] d, input logic [1:0] r,
                      input logic l);
    chk({t, "_data"}, rdv[i], d);
    chk({t, "_resp"}, rrv[i], r);
    chk({t, "_last"}, rlv[i], l);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge ACLK);
    chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);   chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0);         chk("rst_bresp", BRESP, 0);
    chk("rst_rid", RID, 0);         chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    ARESET = 0;
    #1;
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_arready", ARREADY, 1);

    // 4-beat INCR write then stalled read-back
    wr(4'd3, 32'h10, 4'd3, 2'b01, 32'hA0, 4'hF, 3, bid, bresp);
    chk("incr_bid", bid, 3); chk("incr_bresp", bresp, 2'b00);
    rd(4'd5, 32'h10, 4'd3, 2'b01, 1, 2);
    chk("incr_rid", rid_g, 5);
    beat("incr_b0", 0, 32'hA0, 2'b00, 0);
    beat("incr_b1", 1, 32'hA1, 2'b00, 0);
    beat("incr_b2", 2, 32'hA2, 2'b00, 0);
    beat("incr_b3", 3, 32'hA3, 2'b00, 1);

    // byte strobe merge
    wr(4'd1, 32'h10, 4'd0, 2'b01, 32'h0000BB00, 4'b0010, 0, bid, bresp);
    chk("strb_bresp", bresp, 2'b00);
    rd(4'd1, 32'h10, 4'd0, 2'b01, -1, 0);
    beat("strb", 0, 32'h0000BBA0, 2'b00, 1);

    // early WLAST: SLVERR but data still written
    wr(4'd2, 32'h40, 4'd1, 2'b01, 32'h11, 4'hF, 0, bid, bresp);
    chk("wlast_bid", bid, 2); chk("wlast_bresp", bresp, 2'b10);
    rd(4'd2, 32'h40, 4'd1, 2'b01, -1, 0);
    beat("wlast_b0", 0, 32'h11, 2'b00, 0);
    beat("wlast_b1", 1, 32'h12, 2'b00, 1);

    // missing WLAST on final beat
    wr(4'd2, 32'h48, 4'd0, 2'b01, 32'h33, 4'hF, -1, bid, bresp);
    chk("nolast_bresp", bresp, 2'b10);

    // top-of-memory: out-of-range beat is blocked and reads as zero
    wr(4'd4, 32'h0, 4'd0, 2'b01, 32'h77, 4'hF, 0, bid, bresp);
    chk("w0_bresp", bresp, 2'b00);
    wr(4'd4, 32'hFC, 4'd1, 2'b01, 32'h55, 4'hF, 1, bid, bresp);
    chk("oob_bresp", bresp, 2'b10);
    rd(4'd6, 32'hFC, 4'd1, 2'b01, -1, 0);
    beat("oob_b0", 0, 32'h55, 2'b00, 0);
    beat("oob_b1", 1, 32'h0, 2'b10, 1);
    rd(4'd6, 32'h0, 4'd0, 2'b01, -1, 0);
    beat("oob_nowrap", 0, 32'h77, 2'b00, 1);

    // WRAP burst
    rd(4'd7, 32'h1C, 4'd3, 2'b10, -1, 0);
`ifdef AXI_SLAVE_WRAP_EN
    beat("wrap_b0", 0, 32'hA3, 2'b00, 0);
    beat("wrap_b1", 1, 32'h0000BBA0, 2'b00, 0);
    beat("wrap_b2", 2, 32'hA1, 2'b00, 0);
    beat("wrap_b3", 3, 32'hA2, 2'b00, 1);
`else
    beat("wrap_b0", 0, 32'h0, 2'b10, 0);
    beat("wrap_b1", 1, 32'h0, 2'b10, 0);
    beat("wrap_b2", 2, 32'h0, 2'b10, 0);
    beat("wrap_b3", 3, 32'h0, 2'b10, 1);
`endif

    // FIXED burst keeps rewriting one word
    wr(4'd8, 32'h20, 4'd2, 2'b00, 32'hC0, 4'hF, 2, bid, bresp);
    chk("fixed_bresp", bresp, 2'b00);
    rd(4'd8, 32'h20, 4'd0, 2'b01, -1, 0);
    beat("fixed", 0, 32'hC2, 2'b00, 1);

    // unsupported size
    sz = 3'b001;
    wr(4'd9, 32'h10, 4'd0, 2'b01, 32'hFFFFFFFF, 4'hF, 0, bid, bresp);
    chk("size_bresp", bresp, 2'b10);
    rd(4'd9, 32'h10, 4'd0, 2'b01, -1, 0);
    beat("size_rd", 0, 32'h0, 2'b10, 1);
    sz = 3'b010;
    // reserved burst type 2'b11
    rd(4'd9, 32'h10, 4'd0, 2'b11, -1, 0);
    beat("rsvd_rd", 0, 32'h0, 2'b10, 1);
    rd(4'd9, 32'h10, 4'd0, 2'b01, -1, 0);
    beat("size_nowrite", 0, 32'h0000BBA0, 2'b00, 1);

    // simultaneous AW and AR
    fork
      wr(4'd10, 32'h30, 4'd0, 2'b01, 32'hD0, 4'hF, 0, bid, bresp);
      rd(4'd11, 32'h14, 4'd0, 2'b01, -1, 0);
    join
    chk("both_bid", bid, 10); chk("both_bresp", bresp, 2'b00);
    chk("both_rid", rid_g, 11);
    beat("both_rd", 0, 32'hA1, 2'b00, 1);
    rd(4'd11, 32'h30, 4'd0, 2'b01, -1, 0);
    beat("both_wr", 0, 32'hD0, 2'b00, 1);

    // reset mid-burst abandons the burst but keeps memory
    @(negedge ACLK);
    AWID = 4'd12; AWADDR = 32'h60; AWLEN = 4'd3; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1;
    chk("mid_awready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 0; WDATA = 32'hE0; WSTRB = 4'hF; WLAST = 0; WVALID = 1;
    chk("mid_wready", WREADY, 1);
    @(negedge ACLK);
    WVALID = 0; ARESET = 1;
    #1;
    chk("mid_rst_wready", WREADY, 0);
    chk("mid_rst_bvalid", BVALID, 0);
    @(negedge ACLK);
    ARESET = 0; BREADY = 1;
    #1;
    chk("mid_post_awready", AWREADY, 1);
    repeat (3) @(negedge ACLK);
    chk("mid_no_b", BVALID, 0);
    BREADY = 0;
    rd(4'd13, 32'h60, 4'd0, 2'b01, -1, 0);
    beat("mid_mem", 0, 32'hE0, 2'b00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
